memb_stream_reader: RTL and testbench
=====================================

# memb_stream_reader

Drain stage directly downstream of memory B in the memory-transfer datapath. After the transfer controller finishes copying memory A into memory B, it pulses `start` with the number of words moved. This block then reads memory B from address 0 upward and streams each word out on a valid/ready interface. Along the way it produces a `last` marker, a completion pulse and an 8-bit running checksum for the system-level check.

## Interface
- `DATA_W`, 8, word width (matches `DatainA`)
- `ADDR_W`, 3, memory B address width; depth `DEPTH = 2**ADDR_W` (8)

- `clock`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted)
- `start`  in  1  one-cycle pulse from the transfer controller: memory B is filled
- `count`  in  ADDR_W+1  number of valid words in memory B; sampled with `start`
- `rd_en`  out  1  memory B read strobe
- `rd_addr`  out  ADDR_W  memory B read address
- `rd_data`  in  DATA_W  memory B read data, valid exactly 1 cycle after `rd_en`
- `dout`  out  DATA_W  streamed word
- `dout_valid`  out  1  `dout` is valid
- `dout_ready`  in  1  consumer accepts `dout`
- `dout_last`  out  1  qualifies the final word of the burst
- `busy`  out  1  burst in progress
- `done`  out  1  one-cycle pulse when the burst completes
- `checksum`  out  DATA_W  modulo-2^DATA_W sum of the words accepted in this burst

## Operation
- States:
  - IDLE → RUN on `start`.
  - RUN → DRAIN when `count` reads have been issued.
  - DRAIN → DONE when the FIFO is empty and no read is in flight.
  - DONE → IDLE unconditionally after 1 cycle.
- `count` handling:
  - latched as `n = min(count, DEPTH)`; values above `DEPTH` saturate.
  - `n = 0` goes IDLE → DONE directly, with no `rd_en` and no `dout_valid`.
- Read issue:
  - a read is issued only while issued < n, and only when (FIFO occupancy + in-flight − pop this cycle) < 2.
  - addresses run 0, 1, …, n−1 with no wrap; `rd_addr` never exceeds n−1.
- Buffering: `rd_data` is captured into a 2-entry output FIFO on the cycle it is valid. `dout`/`dout_valid` reflect the FIFO head.
- Handshake:
  - a word transfers on a cycle with `dout_valid & dout_ready`.
  - `dout` and `dout_last` must stay stable while `dout_valid & !dout_ready`.
  - `dout_valid` never drops without a transfer.
- `dout_last` is high only with the n-th word.
- `checksum`:
  - cleared on accepted `start`.
  - adds each transferred word, with carry discarded.
  - holds its value after `done` until the next accepted `start`.
- `busy` is high in RUN, DRAIN and DONE.
- `start` is ignored unless the state is IDLE. This includes a `start` arriving in the same cycle as the `done` pulse.
- Reset (asynchronous, any time): state IDLE, FIFO and counters cleared. All outputs are 0: `rd_en`, `rd_addr`, `dout`, `dout_valid`, `dout_last`, `busy`, `done`, `checksum`. A partial burst is discarded and not resumed.

## Timing
- `start` sampled at edge E0:
  - `rd_en` with addr 0 in cycle 1.
  - `rd_data` captured at the end of cycle 2.
  - first `dout_valid` in cycle 3.
- With `dout_ready` held high, throughput is 1 word/cycle. Word k appears in cycle 3+k.
- `done` is asserted the cycle after the final transfer, and lasts exactly 1 cycle.
- For `n = 0`, `done` is asserted in cycle 1.
- Back-pressure stalls read issue within 1 cycle; the FIFO never overflows.

## Structure
- Shared package `memxfer_pkg`:
  - `DATA_W`/`ADDR_W` defaults
  - state enum {IDLE, RUN, DRAIN, DONE}
  - checksum width constant, shared with the controller and bench
- Sub-module `memb_out_fifo`: 2-entry synchronous FIFO with push/pop, occupancy, head data and head-last flag. The top level holds the FSM, address/issue counters, in-flight flag and checksum.

## Test plan
- Memory B = 1..8, `count` = 5, `dout_ready` = 1:
  - `dout` 1, 2, 3, 4, 5 in cycles 3–7.
  - `dout_last` with 5.
  - `done` in cycle 8.
  - `checksum` = 0x0F.
- `count` = 8, `dout_ready` toggling 1,0,0,1,…:
  - all of 1..8 delivered in order, none lost or duplicated.
  - `dout` stable during stalls.
  - `rd_addr` max 7.
  - `checksum` = 0x24.
- `count` = 0:
  - no `rd_en`, no `dout_valid`.
  - `done` in cycle 1.
  - `checksum` = 0.
- `count` = 12: saturates to 8 words; `checksum` = 0x24. Additionally:
  - a second `start` during RUN is ignored.
  - a `start` in the `done` cycle is ignored.
- `reset` driven low after 3 transfers, mid-burst:
  - all outputs 0 immediately, asynchronously.
  - after release, `start` with `count` = 2 yields 1, 2 from address 0, with `checksum` = 0x03.

Source files
------------

// File: rtl/memxfer_pkg.sv
// Shared definitions for the memory-transfer datapath: widths, drain-stage states,
// output FIFO entry layout and the count saturation helper.
package memxfer_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned CSUM_W = DATA_W;
    localparam int unsigned OCC_W  = 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } fifo_entry_t;

    // Word count clamped to the memory depth.
    function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] cnt);
        return (cnt > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : cnt;
    endfunction

endpackage

// File: rtl/memb_stream_reader_if.sv
// Bus bundle of the memory B drain stage: control, memory B read port,
// output stream and status.
interface memb_stream_reader_if;
    import memxfer_pkg::*;

    logic              start;
    logic [CNT_W-1:0]  count;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic              dout_last;
    logic              busy;
    logic              done;
    logic [CSUM_W-1:0] checksum;

    modport master (
        input  start, count, rd_data, dout_ready,
        output rd_en, rd_addr, dout, dout_valid, dout_last, busy, done, checksum
    );

    modport slave (
        output start, count, rd_data, dout_ready,
        input  rd_en, rd_addr, dout, dout_valid, dout_last, busy, done, checksum
    );

endinterface

// File: rtl/memb_out_fifo.sv
// Two-entry shift FIFO buffering memory B words; the head entry and its
// valid flag are registered so the stream outputs come straight from flops.
module memb_out_fifo
    import memxfer_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  fifo_entry_t      push_entry,
    input  logic             pop,
    output logic [OCC_W-1:0] occ,
    output logic             head_valid,
    output fifo_entry_t      head
);

    fifo_entry_t      head_q, head_d;
    fifo_entry_t      tail_q, tail_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             valid_q;

    // Pop shifts the tail forward (emptied slots read as zero), then push fills the first free slot.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (pop) begin
            head_d = tail_q;
            tail_d = '0;
            occ_d  = occ_q - OCC_W'(1);
        end
        if (push) begin
            if (occ_d == '0) begin
                head_d = push_entry;
            end else begin
                tail_d = push_entry;
            end
            occ_d = occ_d + OCC_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            occ_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            occ_q   <= occ_d;
            valid_q <= (occ_d != '0);
        end
    end

    assign occ        = occ_q;
    assign head_valid = valid_q;
    assign head       = head_q;

endmodule

// File: rtl/memb_stream_reader.sv
// Memory B drain stage: reads n = min(count, DEPTH) words from address 0 upward and
// streams them on valid/ready with a last marker, done pulse and running checksum.
module memb_stream_reader
    import memxfer_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    memb_stream_reader_if.master bus
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [CNT_W-1:0]  issued_q, issued_d;
    logic [CNT_W-1:0]  sat_c;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CSUM_W-1:0] csum_q, csum_d;
    logic              inflight_q, inflight_last_q;
    logic              busy_q, done_q;

    logic              pop_c, room_c, issue_c, last_issue_c, drained_c;
    logic [OCC_W-1:0]  fifo_occ;
    logic              fifo_head_valid;
    fifo_entry_t       fifo_head;
    fifo_entry_t       push_entry;

    // Read data arrives one cycle after the strobe and is captured into the FIFO that cycle.
    always_comb begin
        push_entry.last = inflight_last_q;
        push_entry.data = bus.rd_data;
    end

    memb_out_fifo u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (inflight_q),
        .push_entry (push_entry),
        .pop        (pop_c),
        .occ        (fifo_occ),
        .head_valid (fifo_head_valid),
        .head       (fifo_head)
    );

    // A new read may only issue if its word is guaranteed a slot even if the consumer stalls.
    always_comb begin
        pop_c        = fifo_head_valid & bus.dout_ready;
        room_c       = ((OCC_W+1)'(fifo_occ) + (OCC_W+1)'(inflight_q))
                       < ((OCC_W+1)'(2) + (OCC_W+1)'(pop_c));
        issue_c      = (state_q == RUN) && (issued_q < n_q) && room_c;
        last_issue_c = issue_c && (issued_q == n_q - CNT_W'(1));
        drained_c    = !inflight_q
                       && ((fifo_occ == '0) || ((fifo_occ == OCC_W'(1)) && pop_c));
    end

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        issued_d = issued_q;
        addr_d   = addr_q;
        csum_d   = pop_c ? csum_q + fifo_head.data : csum_q;
        sat_c    = sat_count(bus.count);
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    n_d      = sat_c;
                    issued_d = '0;
                    addr_d   = '0;
                    csum_d   = '0;
                    state_d  = (sat_c == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // Address stops at n-1 so it never points past the burst.
                if (issue_c) begin
                    issued_d = issued_q + CNT_W'(1);
                    if (last_issue_c) begin
                        state_d = DRAIN;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (drained_c) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            n_q             <= '0;
            issued_q        <= '0;
            addr_q          <= '0;
            csum_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            n_q             <= n_d;
            issued_q        <= issued_d;
            addr_q          <= addr_d;
            csum_q          <= csum_d;
            inflight_q      <= issue_c;
            inflight_last_q <= last_issue_c;
            busy_q          <= (state_d != IDLE);
            done_q          <= (state_d == DONE);
        end
    end

    assign bus.rd_en      = issue_c;
    assign bus.rd_addr    = addr_q;
    assign bus.dout       = fifo_head.data;
    assign bus.dout_valid = fifo_head_valid;
    assign bus.dout_last  = fifo_head.last;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.checksum   = csum_q;

endmodule

// File: tb/tb_memb_stream_reader.sv
// Directed and randomized bursts through memb_stream_reader, checked against a
// word-list/sum model of memory B and the stream timing rules.
module tb_memb_stream_reader;
    import memxfer_pkg::*;

    logic clock = 1'b0;
    logic reset;

    memb_stream_reader_if bus();

    memb_stream_reader dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    logic [DATA_W-1:0] memb [DEPTH];
    int n_cmp = 0;
    int n_bad = 0;

    // Memory B: registered read, garbage on the bus when not strobed.
    always @(posedge clock) bus.rd_data <= bus.rd_en ? memb[bus.rd_addr] : DATA_W'($urandom);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rd_en"},      32'(bus.rd_en),      0);
        chk({tag, "_rd_addr"},    32'(bus.rd_addr),    0);
        chk({tag, "_dout"},       32'(bus.dout),       0);
        chk({tag, "_dout_valid"}, 32'(bus.dout_valid), 0);
        chk({tag, "_dout_last"},  32'(bus.dout_last),  0);
        chk({tag, "_busy"},       32'(bus.busy),       0);
        chk({tag, "_done"},       32'(bus.done),       0);
        chk({tag, "_checksum"},   32'(bus.checksum),   0);
    endtask

    // One burst: start in cycle 0, then watch every cycle until a few cycles past done.
    task automatic run_burst(input int cnt, input int mode, input bit timing,
                             input int start2_cyc, input bit start_at_done);
        int n, exp_sum, got, reads, done_cyc, done_pulses, busy_cnt, last_xfer, valid_cnt;
        bit rdy, prev_stall;
        logic [DATA_W-1:0] prev_dout;
        logic prev_last;
        n = (cnt > int'(DEPTH)) ? int'(DEPTH) : cnt;
        exp_sum = 0;
        for (int i = 0; i < n; i++) exp_sum = (exp_sum + int'(memb[i])) % 256;
        got = 0; reads = 0; done_cyc = -1; done_pulses = 0; busy_cnt = 0;
        last_xfer = -1; valid_cnt = 0; prev_stall = 1'b0; prev_dout = '0; prev_last = 1'b0;
        for (int cyc = 0; cyc < 120; cyc++) begin
            @(negedge clock);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = ($urandom_range(0, 9) < 7);
            endcase
            bus.dout_ready = rdy;
            bus.start = (cyc == 0) || (cyc == start2_cyc) || (start_at_done && bus.done === 1'b1);
            bus.count = (cyc == 0) ? CNT_W'(cnt) : CNT_W'(3);
            #1;
            if (prev_stall) begin
                chk("stall_valid", 32'(bus.dout_valid), 1);
                chk("stall_dout",  32'(bus.dout),       32'(prev_dout));
                chk("stall_last",  32'(bus.dout_last),  32'(prev_last));
            end
            if (bus.rd_en === 1'b1) begin
                chk("rd_addr", 32'(bus.rd_addr), reads);
                reads++;
            end
            if (bus.dout_valid === 1'b1) valid_cnt++;
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.dout_valid === 1'b1 && rdy) begin
                if (got < n) begin
                    chk("dout",      32'(bus.dout),      32'(memb[got]));
                    chk("dout_last", 32'(bus.dout_last), 32'(got == n - 1));
                    if (timing) chk("xfer_cycle", cyc, 3 + got);
                end else begin
                    chk("extra_word", got, n);
                end
                got++;
                last_xfer = cyc;
            end
            if (bus.done === 1'b1) begin
                done_pulses++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc > done_cyc)
                chk("idle_after_done", 32'({bus.busy, bus.rd_en, bus.dout_valid}), 0);
            prev_stall = (bus.dout_valid === 1'b1) && !rdy;
            prev_dout  = bus.dout;
            prev_last  = bus.dout_last;
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
        end
        bus.start = 1'b0;
        chk("words",       got,         n);
        chk("reads",       reads,       n);
        chk("done_pulses", done_pulses, 1);
        chk("done_cycle",  done_cyc,    (n == 0) ? 1 : last_xfer + 1);
        chk("busy_cycles", busy_cnt,    done_cyc);
        if (n == 0) chk("valid_cycles_n0", valid_cnt, 0);
        chk("checksum",    32'(bus.checksum), exp_sum);
    endtask

    initial begin
        reset = 1'b0;
        bus.start = 1'b0;
        bus.count = '0;
        bus.dout_ready = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) memb[i] = DATA_W'(i + 1);
        repeat (3) @(negedge clock);
        check_zero("reset");
        reset = 1'b1;

        // Five words at full rate
        run_burst(5, 0, 1'b1, -1, 1'b0);
        chk("checksum_a", 32'(bus.checksum), 32'h0F);

        // Full memory with a 1,0,0 ready pattern
        run_burst(8, 1, 1'b0, -1, 1'b0);
        chk("checksum_b", 32'(bus.checksum), 32'h24);

        // Empty burst
        run_burst(0, 0, 1'b1, -1, 1'b0);
        chk("checksum_c", 32'(bus.checksum), 32'h00);

        // Saturating count, restart attempts during RUN and in the done cycle
        run_burst(12, 0, 1'b1, 2, 1'b1);
        chk("checksum_d", 32'(bus.checksum), 32'h24);

        // Reset mid-burst after three transfers
        bus.dout_ready = 1'b1;
        @(negedge clock);
        bus.start = 1'b1;
        bus.count = CNT_W'(8);
        @(negedge clock);
        bus.start = 1'b0;
        repeat (5) @(negedge clock);
        #1;
        chk("pre_reset_checksum", 32'(bus.checksum), 32'h06);
        #2;
        reset = 1'b0;
        #1;
        check_zero("async_reset");
        @(negedge clock);
        reset = 1'b1;
        run_burst(2, 0, 1'b1, -1, 1'b0);
        chk("checksum_e", 32'(bus.checksum), 32'h03);

        // Random contents, counts and consumer behaviour
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < int'(DEPTH); i++) memb[i] = DATA_W'($urandom);
            run_burst(int'($urandom_range(0, 15)), r % 3, (r % 3) == 0, -1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
